// File: rtl/bcd_adder_serial_pkg.sv
// bcd_adder_serial_pkg: shared BCD constants and FSM encoding for the serial BCD adder
package bcd_adder_serial_pkg;
  localparam int BCD_W = 4;
  localparam int BCD_MAX_DIGIT = 9;
  localparam int BCD_CORR = 6;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/bcd_adder_serial_digit_add.sv
// bcd_digit_add: one BCD digit plus carry with decimal correction and invalid-digit flag
module bcd_digit_add
  import bcd_adder_serial_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] s,
  output logic       co,
  output logic       bad
);
  logic [4:0] raw;
  assign raw = 5'(a) + 5'(b) + 5'(c);
  assign co  = raw > 5'(BCD_MAX_DIGIT);
  assign s   = co ? 4'(raw + 5'(BCD_CORR)) : raw[3:0];
  assign bad = (a > 4'(BCD_MAX_DIGIT)) || (b > 4'(BCD_MAX_DIGIT));
endmodule

// File: rtl/bcd_adder_serial.sv
// bcd_adder_serial: digit-serial multi-digit BCD adder, LSD first; BCD_SUB_EN adds ten's-complement subtract
module bcd_adder_serial
  import bcd_adder_serial_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef BCD_SUB_EN
  input  logic                  sub,
`endif
  input  logic                  start,
  input  logic [BCD_W*DIGITS-1:0] in0,
  input  logic [BCD_W*DIGITS-1:0] in1,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [BCD_W*DIGITS-1:0] out0,
  output logic                  out1,
  output logic                  err
);
  localparam int W = BCD_W * DIGITS;
  localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
  state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, out1_q, out1_d, err_q, err_d, done_q, done_d, sub_q, sub_d, sub_in;
  logic [3:0] b_dig, s;
  logic co, bad;
`ifdef BCD_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif
  // 9-b maps every invalid digit (10..15) onto another invalid digit, so bad still flags the original B
  assign b_dig = sub_q ? 4'(BCD_MAX_DIGIT) - b_q[3:0] : b_q[3:0];
  bcd_digit_add u_add (
    .a  (a_q[3:0]),
    .b  (b_dig),
    .c  (c_q),
    .s  (s),
    .co (co),
    .bad(bad)
  );
  assign busy = state_q == RUN;
  assign done = done_q;
  assign out0 = sum_q;
  assign out1 = out1_q;
  assign err  = err_q;
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      out1_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      out1_q  <= out1_d;
      err_q   <= err_d;
      done_q  <= done_d;
      sub_q   <= sub_d;
    end
  end
  // capture on accepted start, then consume one digit per cycle shifting the sum in at the MSD end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    out1_d  = out1_q;
    err_d   = err_q;
    done_d  = 1'b0;
    sub_d   = sub_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        a_d     = in0;
        b_d     = in1;
        c_d     = sub_in | cin;
        sub_d   = sub_in;
        sum_d   = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
    end else begin
      a_d   = a_q >> BCD_W;
      b_d   = b_q >> BCD_W;
      c_d   = co;
      sum_d = (sum_q >> BCD_W) | (W'(s) << (W - BCD_W));
      err_d = err_q | bad;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = IDLE;
        out1_d  = co;
        done_d  = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bcd_adder_serial.sv
// tb_bcd_adder_serial: directed checks of the 4-digit serial BCD adder (sub checks when BCD_SUB_EN is defined)
module tb_bcd_adder_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cin = 1'b0;
  logic sub = 1'b0;
  logic [15:0] in0 = '0, in1 = '0;
  logic busy, done, out1, err;
  logic [15:0] out0;
  int passed = 0;
  int total = 0;
  int n;
  bcd_adder_serial #(.DIGITS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef BCD_SUB_EN
    .sub  (sub),
`endif
    .start(start),
    .in0  (in0),
    .in1  (in1),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .out0 (out0),
    .out1 (out1),
    .err  (err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic go(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sb);
    in0 = a;
    in1 = b;
    cin = c;
    sub = sb;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("done_after_start", done, 1'b0);
  endtask
  task automatic wait_done(input string tag, input int cycles, input logic [15:0] s,
                           input logic c, input logic e);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, cycles);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_out0"}, out0, s);
    chk({tag, "_out1"}, out1, c);
    chk({tag, "_err"}, err, e);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out0", out0, 16'h0);
    chk("rst_out1", out1, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    tick();
    go(16'h1234, 16'h5678, 1'b0, 1'b0);
    in0 = 16'h9999;
    in1 = 16'h9999;
    wait_done("add_1234_5678", 4, 16'h6912, 1'b0, 1'b0);
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("out0_holds", out0, 16'h6912);
    go(16'h9999, 16'h0001, 1'b0, 1'b0);
    wait_done("add_9999_0001", 4, 16'h0000, 1'b1, 1'b0);
    go(16'h9999, 16'h9999, 1'b1, 1'b0);
    wait_done("add_9999_9999_c", 4, 16'h9999, 1'b1, 1'b0);
    go(16'h1234, 16'h5678, 1'b0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_out0", out0, 16'h0);
    chk("abort_out1", out1, 1'b0);
    chk("abort_err", err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", done, 1'b0);
    end
    rst_n = 1'b1;
    tick();
    go(16'h4321, 16'h1234, 1'b0, 1'b0);
    wait_done("after_abort", 4, 16'h5555, 1'b0, 1'b0);
    go(16'h12A4, 16'h0000, 1'b0, 1'b0);
    wait_done("bad_digit", 4, 16'h1304, 1'b0, 1'b1);
    tick();
    chk("err_sticky", err, 1'b1);
    go(16'h0001, 16'h0002, 1'b0, 1'b0);
    chk("err_cleared_on_start", err, 1'b0);
    wait_done("err_clear", 4, 16'h0003, 1'b0, 1'b0);
    go(16'h1111, 16'h2222, 1'b0, 1'b0);
    tick();
    go(16'h5555, 16'h5555, 1'b0, 1'b0);
    wait_done("ignored_start", 2, 16'h3333, 1'b0, 1'b0);
    go(16'h1111, 16'h1111, 1'b0, 1'b0);
    wait_done("start_on_done", 4, 16'h2222, 1'b0, 1'b0);
`ifdef BCD_SUB_EN
    go(16'h5000, 16'h1234, 1'b0, 1'b1);
    wait_done("sub_pos", 4, 16'h3766, 1'b1, 1'b0);
    go(16'h1234, 16'h5000, 1'b0, 1'b1);
    wait_done("sub_neg", 4, 16'h6234, 1'b0, 1'b0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
